// File: rtl/seq_detect_pkg.sv
// Shared definitions for the parametrised serial sequence detector:
// default pattern, fill-counter sizing and the overlap-mode encoding.
package seq_detect_pkg;

    localparam logic [7:0] SEQ_DEFAULT_PAT = 8'b0101_0101;

    typedef enum logic {
        MODE_NOOVL = 1'b0,
        MODE_OVL   = 1'b1
    } overlap_mode_e;

    // Fill counter must represent 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_window.sv
// Serial shift window with a saturating count of valid bits held.
// Exposes the window/fill state the next shift would produce so the caller can compare early.
module seq_window #(
    parameter int PAT_W  = 8,
    parameter int FILL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift,
    input  logic             restart,
    input  logic             din,
    output logic [PAT_W-1:0] next_win,
    output logic             next_full
);

    logic [PAT_W-1:0]  window_r;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] next_fill_s;

    assign next_win  = {window_r[PAT_W-2:0], din};
    assign next_full = (fill_r >= FILL_W'(PAT_W - 1));

    // Fill saturates at PAT_W once the window holds a full pattern's worth of bits.
    always_comb begin
        next_fill_s = fill_r;
        if (fill_r == FILL_W'(PAT_W)) begin
            next_fill_s = fill_r;
        end else begin
            next_fill_s = fill_r + FILL_W'(1);
        end
    end

    // Window and fill state; clr drops progress but leaves stale bits, which fill masks out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            window_r <= {PAT_W{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
        end else if (clr) begin
            window_r <= window_r;
            fill_r   <= {FILL_W{1'b0}};
        end else if (shift) begin
            window_r <= next_win;
            fill_r   <= restart ? {FILL_W{1'b0}} : next_fill_s;
        end else begin
            window_r <= window_r;
            fill_r   <= fill_r;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-loadable serial pattern detector with overlap control,
// registered one-cycle match flag and saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W       = 8,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(SEQ_DEFAULT_PAT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int FILL_W = fill_width(PAT_W);

    logic [PAT_W-1:0] pattern_r;
    logic             flag_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sat_r;

    logic             accept_s;
    logic             hit_s;
    logic             restart_s;
    logic [PAT_W-1:0] next_win_s;
    logic             next_full_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    overlap_mode_e    mode_s;

    // A pattern load takes the cycle, so a coincident data bit is dropped.
    assign accept_s  = din_valid && !pat_load;
    assign mode_s    = overlap_mode_e'(overlap_en);
    assign hit_s     = accept_s && next_full_s && (next_win_s == pattern_r);
    assign restart_s = hit_s && (mode_s == MODE_NOOVL);

    seq_window #(
        .PAT_W  (PAT_W),
        .FILL_W (FILL_W)
    ) u_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pat_load),
        .shift     (accept_s),
        .restart   (restart_s),
        .din       (din),
        .next_win  (next_win_s),
        .next_full (next_full_s)
    );

    // Counter next state: a clear coinciding with a hit counts that hit.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (cnt_clr) begin
            cnt_nxt_s = hit_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (hit_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Pattern register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern_r <= DEFAULT_PAT;
            flag_r    <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            sat_r     <= 1'b0;
        end else begin
            if (pat_load) begin
                pattern_r <= pat_in;
            end else begin
                pattern_r <= pattern_r;
            end
            flag_r <= hit_s;
            cnt_r  <= cnt_nxt_s;
            sat_r  <= (cnt_nxt_s == {CNT_W{1'b1}});
        end
    end

    assign flag      = flag_r;
    assign match_cnt = cnt_r;
    assign cnt_sat   = sat_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a bit-history model checked every cycle
// against two instances (CNT_W=8 and CNT_W=2), plus hand-computed spot checks.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din_valid;
    logic       din;
    logic       pat_load;
    logic [7:0] pat_in;
    logic       overlap_en;
    logic       cnt_clr;

    logic       flag_a, sat_a;
    logic [7:0] cnt_a;
    logic       flag_b, sat_b;
    logic [1:0] cnt_b;

    int vectors     = 0;
    int miscompares = 0;

    seq_detect_param #(.PAT_W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en),
        .cnt_clr(cnt_clr), .flag(flag_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
    );

    seq_detect_param #(.PAT_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en),
        .cnt_clr(cnt_clr), .flag(flag_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    always #5 clk = ~clk;

    // Model: the accepted bits since the last restart, plus plain integer counters.
    bit   hist[$];
    logic [7:0] m_pat;
    bit   m_flag;
    int   m_cnt_a;
    int   m_cnt_b;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit hit;
        logic [7:0] v;
        hit = 1'b0;
        if (!rst_n) begin
            hist.delete();
            m_pat   = 8'b0101_0101;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            if (pat_load) begin
                m_pat = pat_in;
                hist.delete();
            end else if (din_valid) begin
                hist.push_back(din);
                if (hist.size() > 8) void'(hist.pop_front());
                if (hist.size() == 8) begin
                    v = 8'h00;
                    foreach (hist[i]) v = {v[6:0], hist[i]};
                    hit = (v == m_pat);
                end
                if (hit && !overlap_en) hist.delete();
            end
            if (cnt_clr) begin
                m_cnt_a = hit ? 1 : 0;
                m_cnt_b = hit ? 1 : 0;
            end else if (hit) begin
                m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
                m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
            end
        end
        m_flag = hit;
        #1;
        check("flag_a", int'(flag_a), int'(m_flag));
        check("cnt_a",  int'(cnt_a),  m_cnt_a);
        check("sat_a",  int'(sat_a),  int'(m_cnt_a == 255));
        check("flag_b", int'(flag_b), int'(m_flag));
        check("cnt_b",  int'(cnt_b),  m_cnt_b);
        check("sat_b",  int'(sat_b),  int'(m_cnt_b == 3));
    end

    // Drive one cycle at the falling edge; return just after the next rising edge.
    task automatic drive(input logic v, input logic d, input logic ld = 1'b0,
                         input logic [7:0] pin = 8'h00, input logic clr = 1'b0);
        @(negedge clk);
        rst_n     = 1'b1;
        din_valid = v;
        din       = d;
        pat_load  = ld;
        pat_in    = pin;
        cnt_clr   = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        pat_load  = 1'b0;
        cnt_clr   = 1'b0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [15:0] alt;
        alt        = 16'b0101_0101_0101_0101;
        rst_n      = 1'b0;
        din_valid  = 1'b0;
        din        = 1'b0;
        pat_load   = 1'b0;
        pat_in     = 8'h00;
        overlap_en = 1'b1;
        cnt_clr    = 1'b0;
        reset_cycle();
        reset_cycle();
        check("reset_flag", int'(flag_a), 0);
        check("reset_cnt",  int'(cnt_a), 0);
        check("reset_sat",  int'(sat_b), 0);

        // Basic match, then overlapping continuation
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, alt[15 - i]);
            if (i == 6) check("pre8_flag", int'(flag_a), 0);
        end
        check("basic_flag", int'(flag_a), 1);
        check("basic_cnt",  int'(cnt_a), 1);
        drive(1'b1, 1'b0);
        check("bit9_flag", int'(flag_a), 0);
        drive(1'b1, 1'b1);
        check("ovl_flag", int'(flag_a), 1);
        check("ovl_cnt",  int'(cnt_a), 2);

        // Non-overlapping: next match needs 8 fresh bits
        reset_cycle();
        overlap_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, alt[15 - i]);
            if (i == 9)  check("novl_bit10", int'(flag_a), 0);
            if (i == 15) check("novl_bit16", int'(flag_a), 1);
        end
        check("novl_cnt", int'(cnt_a), 2);

        // Gaps with din toggling while invalid
        reset_cycle();
        overlap_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, alt[15 - i]);
            if (i == 7) check("gap_flag", int'(flag_a), 1);
            drive(1'b0, ~alt[15 - i]);
            if (i == 7) check("gap_after", int'(flag_a), 0);
        end
        check("gap_cnt", int'(cnt_a), 1);

        // Pattern load mid-stream with a coincident valid bit
        reset_cycle();
        for (int i = 0; i < 4; i++) drive(1'b1, alt[15 - i]);
        drive(1'b1, 1'b1, 1'b1, 8'hF0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i < 4) ? 1'b1 : 1'b0);
            if (i == 6) check("load_pre_cnt", int'(cnt_a), 0);
        end
        check("load_flag", int'(flag_a), 1);
        check("load_cnt",  int'(cnt_a), 1);

        // Mid-stream reset discards partial progress
        reset_cycle();
        for (int i = 0; i < 7; i++) drive(1'b1, alt[15 - i]);
        reset_cycle();
        check("mrst_cnt", int'(cnt_a), 0);
        drive(1'b1, 1'b1);
        check("mrst_flag", int'(flag_a), 0);
        for (int i = 0; i < 8; i++) drive(1'b1, alt[15 - i]);
        check("mrst_full", int'(flag_a), 1);

        // Saturation on the narrow counter, then clear coinciding with a hit
        reset_cycle();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, alt[15 - i]);
            if (i == 9)  check("sat_cnt2", int'(cnt_b), 2);
            if (i == 11) check("sat_cnt3", int'(cnt_b), 3);
            if (i == 11) check("sat_flag", int'(sat_b), 1);
            if (i == 15) check("sat_hold", int'(cnt_b), 3);
        end
        check("wide_cnt", int'(cnt_a), 5);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        check("clrhit_b", int'(cnt_b), 1);
        check("clrhit_a", int'(cnt_a), 1);
        check("clrhit_sat", int'(sat_b), 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_only", int'(cnt_a), 0);
        drive(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
